fxp_mac_acc: RTL
================

# fxp_mac_acc

Streaming fixed-point multiply-accumulate stage for the Kalman filter matrix datapath. Accepts operand pairs over a valid/ready stream, forms full-precision 2N-bit products (2·FRAC fractional bits) and sums them in a guarded accumulator. On the beat marked last it rounds, saturates and emits one N-bit FRAC-format dot-product result. It sits directly downstream of the fixed-point multiplier and feeds the state/covariance update registers.

## Interface
- N, `FXP_N: operand/result width.
- FRAC, `FXP_FRAC: fractional bits of operands and result.
- GUARD, 4: accumulator guard bits; max exact vector length is 2^GUARD.
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  N  signed operand A.
- in_b  in  N  signed operand B.
- in_last  in  1  final beat of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  signed rounded/saturated result.
- out_sat  out  1  result was clipped to the N-bit range.
- out_len_err  out  1  vector exceeded 2^GUARD beats; result is unreliable.

## Operation
- Beat accepted when in_valid && in_ready.
- Stage 1: register prod = in_a*in_b (2N bits, signed), plus last and first-of-vector flags.
- Stage 2: accumulator ACC_W = 2N+GUARD bits. First beat of a vector loads the sign-extended prod; later beats add it. No accumulator clear cycle is needed between vectors.
- Beat counter (GUARD+1 bits) counts beats per vector. A beat beyond 2^GUARD sets a sticky len_err for that vector. The accumulator wraps modulo 2^ACC_W in that case.
- FSM states:
  - ACC: in_ready=1. Accepting a beat with in_last moves to FLUSH.
  - FLUSH: in_ready=0. Waits one cycle for stage 2 to absorb the last product, then goes to OUT.
  - OUT: out_valid=1 and outputs are held stable. A handshake moves to ACC and clears the counter and len_err.
- Result formation: r = acc >>> FRAC (arithmetic), with rounding per Configuration.
  - If r > 2^(N-1)-1, output 0x7FF..F with out_sat=1.
  - If r < -2^(N-1), output 0x800..0 with out_sat=1.
  - Otherwise output r[N-1:0] with out_sat=0.
- Single-beat vector (in_last on the first beat) is legal; the result is that product, rounded and saturated.
- in_valid low mid-vector inserts bubbles; the partial sum is held.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, out_len_err=0, FSM=ACC, counter=0.
- Last beat accepted at cycle t: out_valid rises at t+3 (registered outputs).
- Throughput: one beat per cycle within a vector.
- Per-vector overhead is 3 cycles plus any output backpressure.
- in_ready is low from t+1 until the cycle after the output handshake.
- out_valid is never dropped without out_ready.
- Reset asserted mid-vector or mid-OUT discards all state immediately (asynchronous). After reset deasserts, the first accepted beat starts a new vector.

## Configuration
- FXP_MAC_ROUND_EN defined: round-half-up. Add 2^(FRAC-1) to acc before the shift, with the add done at ACC_W+1 bits so it cannot overflow.
- FXP_MAC_ROUND_EN undefined: plain arithmetic-shift truncation (floor), bit-identical to the aligned-slice truncation used elsewhere in the datapath.

## Structure
- fxp_types.vh holds `FXP_N`, `FXP_FRAC`, FSM state encodings, and derived widths (ACC_W).
- One sub-module: fxp_round_sat. It is combinational: acc in; out_data and out_sat out; rounding controlled by the macro. It is registered in fxp_mac_acc.
- The stage-1 product is inline (signed multiply); no separate multiplier instance is used.

## Test plan
All tests use N=16, FRAC=8.
- Single beat 0x0180 × 0x0200 with last -> out_data=0x0300, out_sat=0, out_valid at t+3.
- 3-beat vector (0x0100×0x0100, 0x0080×0xFE00, 0x0040×0x0040) -> out_data=0x0010, out_sat=0.
- Saturation:
  - 4 beats of 0x7FFF×0x7FFF -> out_data=0x7FFF, out_sat=1.
  - 0x8000×0x7FFF -> 0x8000, out_sat=1.
- Rounding ties:
  - 0x0001×0x0080 -> 0x0001 with ROUND_EN, 0x0000 without.
  - 0xFFFF×0x0080 -> 0x0000 with ROUND_EN, 0xFFFF without.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data stable and in_ready=0 throughout.
  - A new vector is accepted from the cycle after the handshake.
- Reset mid-vector:
  - Assert rst_n=0 after 2 of 3 beats -> all outputs at reset values.
  - A following single beat 0x0100×0x0100 -> 0x0100.
- Length error: 17 beats of 0x0100×0x0100 -> out_len_err=1; the next vector reports out_len_err=0.

Source files
------------

// File: rtl/fxp_mac_acc_pkg.sv
// Shared definitions for the fixed-point MAC accumulator.
// Width macros FXP_N / FXP_FRAC default to 16 / 8 when not supplied by the build.
// Rounding mode is selected by FXP_MAC_ROUND_EN (see fxp_round_sat).
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

package fxp_mac_acc_pkg;

    localparam int FXP_N_P     = `FXP_N;
    localparam int FXP_FRAC_P  = `FXP_FRAC;
    localparam int FXP_GUARD_P = 4;
    localparam int FXP_ACC_W   = 2 * FXP_N_P + FXP_GUARD_P;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OUT   = 2'd2
    } mac_state_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational result former: shifts the guarded accumulator down by FRAC
// fractional bits and clips it to the signed DATA_W range.
// FXP_MAC_ROUND_EN defined: round-half-up; undefined: floor truncation.
module fxp_round_sat
    import fxp_mac_acc_pkg::*;
#(
    parameter int DATA_W = FXP_N_P,
    parameter int FRAC   = FXP_FRAC_P,
    parameter int ACC_W  = FXP_ACC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat
);

    // One extra bit so the rounding add can never overflow.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] R_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef FXP_MAC_ROUND_EN
    localparam logic signed [RW-1:0] HALF  = {{(RW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

    function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] ext;
        ext = {a[ACC_W-1], a};
`ifdef FXP_MAC_ROUND_EN
        ext = ext + HALF;
`endif
        return ext >>> FRAC;
    endfunction

    // Returns {sat, data}.
    function automatic logic [DATA_W:0] saturate(input logic signed [RW-1:0] r);
        if (r > R_MAX)
            return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        else if (r < R_MIN)
            return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        return {1'b0, r[DATA_W-1:0]};
    endfunction

    logic [DATA_W:0] sr;

    // Round, then clip to the output range.
    always_comb begin
        sr       = saturate(round_shift(acc));
        out_sat  = sr[DATA_W];
        out_data = sr[DATA_W-1:0];
    end

endmodule

// File: rtl/fxp_mac_acc.sv
// Streaming fixed-point dot-product stage: multiply, guarded accumulate,
// then one rounded/saturated result per vector on a valid/ready output.
// Rounding mode is selected by FXP_MAC_ROUND_EN (default: truncation).
module fxp_mac_acc
    import fxp_mac_acc_pkg::*;
#(
    parameter int DATA_W = FXP_N_P,
    parameter int FRAC   = FXP_FRAC_P,
    parameter int GUARD  = FXP_GUARD_P
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    output logic                     out_len_err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + GUARD;
    localparam logic [GUARD:0] CNT_MAX = {1'b1, {GUARD{1'b0}}};

    mac_state_t state, state_nxt;
    logic beat, load_out;
    logic [GUARD:0] cnt;
    logic len_err;

    logic vld_p0, last_p0, first_p0;
    logic signed [PROD_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]  prod_ext_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic done_p1;

    logic signed [DATA_W-1:0] rs_data;
    logic rs_sat;

    assign beat        = in_valid && in_ready;
    assign prod_ext_p0 = {{GUARD{prod_p0[PROD_W-1]}}, prod_p0};
    // The accumulator holds the final sum in the cycle done_p1 is high.
    assign load_out    = (state == ST_FLUSH) && done_p1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (done_p1) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // Beat counter and sticky length error, cleared by the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (out_valid && out_ready) begin
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (beat) begin
            if (cnt == CNT_MAX) len_err <= 1'b1;
            else                cnt     <= cnt + 1'b1;
        end
    end

    // Pipeline control: stage-0 valid and stage-1 end-of-vector marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p0  <= beat;
            done_p1 <= vld_p0 && last_p0;
        end
    end

    // Stage 0: full-precision product with vector framing flags.
    always_ff @(posedge clk) begin
        if (beat) begin
            prod_p0  <= PROD_W'(in_a) * PROD_W'(in_b);
            last_p0  <= in_last;
            first_p0 <= (cnt == '0);
        end
    end

    // Stage 1: first beat loads, later beats add (wraps modulo 2^ACC_W).
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            if (first_p0) acc_p1 <= prod_ext_p0;
            else          acc_p1 <= acc_p1 + prod_ext_p0;
        end
    end

    fxp_round_sat #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .acc      (acc_p1),
        .out_data (rs_data),
        .out_sat  (rs_sat)
    );

    // Output registers: captured once per vector, held through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_sat     <= 1'b0;
            out_len_err <= 1'b0;
        end else if (load_out) begin
            out_data    <= rs_data;
            out_sat     <= rs_sat;
            out_len_err <= len_err;
        end
    end

endmodule
